ext_arbiter: RTL and testbench

EXT_ARBITER -- requirements
Module: ext_arbiter

---
 rtl/ext_pkg.sv | 23 ++
 rtl/ext_arbiter_extender.sv | 16 +
 rtl/ext_arbiter.sv | 123 ++++++++++++
 tb/tb_ext_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ext_pkg.sv
// ext_pkg
// Shared definitions for the immediate-extension arbiter slice.
//   mode_e  : 2-bit extension mode carried on reqN_mode
//   state_e : result-register occupancy state of ext_arbiter
//   IMM_W / RES_W : raw immediate and extended result widths
package ext_pkg;

  localparam int unsigned IMM_W = 16;
  localparam int unsigned RES_W = 32;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'b00,
    MODE_SIGN = 2'b01,
    MODE_LUI  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/ext_arbiter_extender.sv
// Extender
// Widens a 16-bit immediate to 32 bits, by zero or sign extension.
//   imm16 : raw immediate
//   sign  : 1 = replicate imm16[15], 0 = fill with zeros
//   imm32 : extended immediate
module Extender
  import ext_pkg::*;
(
  input  logic [IMM_W-1:0] imm16,
  input  logic             sign,
  output logic [RES_W-1:0] imm32
);

  assign imm32 = {{(RES_W-IMM_W){sign & imm16[IMM_W-1]}}, imm16};

endmodule

// File: rtl/ext_arbiter.sv
// ext_arbiter
// Two requesters share one immediate extender behind a single-entry
// result register. Round-robin arbitration between requesters, with
// same-cycle drain and refill of the result register.
//   clk, reset        : clock, asynchronous active-low reset
//   reqN_valid/ready  : requester handshake (N = 0, 1)
//   reqN_imm16/mode   : raw immediate and extension mode
//   rsp_valid/ready   : result handshake
//   rsp_id            : requester that owns the current result
//   rsp_imm32         : extended result
//   mode_err          : sticky, set when a RESERVED mode is accepted
module ext_arbiter
  import ext_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IMM_W-1:0] req0_imm16,
  input  logic [1:0]       req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IMM_W-1:0] req1_imm16,
  input  logic [1:0]       req1_mode,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_imm32,
  output logic             mode_err
);

  state_e           state_q;
  state_e           state_d;
  logic             last_q;      // last granted requester; reset to 1 so requester 0 wins first
  logic             accept_ok;
  logic             gnt0;
  logic             gnt1;
  logic             xfer;
  logic [IMM_W-1:0] sel_imm;
  mode_e            sel_mode;
  logic [RES_W-1:0] ext_imm32;
  logic [RES_W-1:0] result;

  // Arbitration. Gating with reset keeps both readies low while reset is
  // asserted, even though the async-cleared state would otherwise allow it.
  always_comb begin
    accept_ok = reset && ((state_q == ST_EMPTY) || rsp_ready);
    gnt0      = accept_ok && req0_valid && (!req1_valid || last_q);
    gnt1      = accept_ok && req1_valid && (!req0_valid || !last_q);
    xfer      = gnt0 || gnt1;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Operand select follows the grant.
  always_comb begin
    sel_imm  = req0_imm16;
    sel_mode = mode_e'(req0_mode);
    if (gnt1) begin
      sel_imm  = req1_imm16;
      sel_mode = mode_e'(req1_mode);
    end
  end

  Extender u_extender (
    .imm16 (sel_imm),
    .sign  (sel_mode == MODE_SIGN),
    .imm32 (ext_imm32)
  );

  always_comb begin
    result = ext_imm32;
    if (sel_mode == MODE_LUI) begin
      result = {sel_imm, {(RES_W-IMM_W){1'b0}}};
    end else if (sel_mode == MODE_RSVD) begin
      result = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_EMPTY) begin
      if (xfer) begin
        state_d = ST_FULL;
      end
    end else begin
      if (rsp_ready && !xfer) begin
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result register, grant pointer and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_id    <= 1'b0;
      rsp_imm32 <= '0;
      last_q    <= 1'b1;
      mode_err  <= 1'b0;
    end else if (xfer) begin
      rsp_id    <= gnt1;
      rsp_imm32 <= result;
      last_q    <= gnt1;
      if (sel_mode == MODE_RSVD) begin
        mode_err <= 1'b1;
      end
    end
  end

  // rsp_valid is a direct decode of the state flop, so it stays registered.
  assign rsp_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;
  import ext_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [15:0] req0_imm16, req1_imm16;
  logic [1:0]  req0_mode, req1_mode;
  logic        rsp_valid, rsp_ready, rsp_id, mode_err;
  logic [31:0] rsp_imm32;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [32:0] sb[$];   // {id, imm32}

  ext_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_imm16 (req0_imm16),
    .req0_mode  (req0_mode),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_imm16 (req1_imm16),
    .req1_mode  (req1_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_imm32  (rsp_imm32),
    .mode_err   (mode_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted result is compared against the scoreboard.
  always @(negedge clk) begin : monitor
    logic [32:0] e;
    if (reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d imm=%h, required none", rsp_id, rsp_imm32);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e[32]));
        chk("rsp_imm32", rsp_imm32, e[31:0]);
      end
    end
  end

  task automatic drive(input bit v0, input logic [1:0] m0, input logic [15:0] i0,
                       input bit v1, input logic [1:0] m1, input logic [15:0] i1,
                       input bit rr);
    req0_valid = v0; req0_mode = m0; req0_imm16 = i0;
    req1_valid = v1; req1_mode = m1; req1_imm16 = i1;
    rsp_ready  = rr;
  endtask

  // Check the expected grant for the current inputs, queue the expected
  // result when a transfer happens, then advance one clock.
  task automatic step(input bit g0, input bit g1, input logic [31:0] exp, input bit push = 1'b1);
    #1;
    chk("req0_ready", 32'(req0_ready), 32'(g0));
    chk("req1_ready", 32'(req1_ready), 32'(g1));
    if ((g0 || g1) && push) sb.push_back({g1, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, MODE_ZERO, 16'h0, 1'b0, MODE_ZERO, 16'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [15:0] imm;
    reset = 1'b0;
    drive(1'b1, MODE_SIGN, 16'h8001, 1'b1, MODE_SIGN, 16'h8001, 1'b1);
    #2;
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_imm", rsp_imm32, 32'h0);
    chk("rst_err", 32'(mode_err), 32'h0);
    chk("rst_ready0", 32'(req0_ready), 32'h0);
    chk("rst_ready1", 32'(req1_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_valid_edge", 32'(rsp_valid), 32'h0);
    reset = 1'b1;

    // Single request, SIGN.
    drive(1'b1, MODE_SIGN, 16'h8001, 1'b0, MODE_ZERO, 16'h0, 1'b1);
    step(1'b1, 1'b0, 32'hFFFF_8001);
    chk("lat_valid", 32'(rsp_valid), 32'h1);
    chk("lat_id", 32'(rsp_id), 32'h0);

    // Mode coverage on requester 1.
    drive(1'b0, MODE_ZERO, 16'h0, 1'b1, MODE_ZERO, 16'h8001, 1'b1);
    step(1'b0, 1'b1, 32'h0000_8001);
    drive(1'b0, MODE_ZERO, 16'h0, 1'b1, MODE_LUI, 16'h8001, 1'b1);
    step(1'b0, 1'b1, 32'h8001_0000);
    chk("err_before_rsvd", 32'(mode_err), 32'h0);
    drive(1'b0, MODE_ZERO, 16'h0, 1'b1, MODE_RSVD, 16'h8001, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0000);
    chk("err_set", 32'(mode_err), 32'h1);
    for (int i = 0; i < 10; i++) begin
      imm = 16'(i) << 8;
      drive(1'b0, MODE_ZERO, 16'h0, 1'b1, MODE_ZERO, imm, 1'b1);
      step(1'b0, 1'b1, {16'h0, imm});
      chk("err_sticky", 32'(mode_err), 32'h1);
    end
    idle();

    // Contention: last grant was requester 1, so 0,1,0,1.
    drive(1'b1, MODE_ZERO, 16'h0A0A, 1'b1, MODE_SIGN, 16'hB0B0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) step(1'b1, 1'b0, 32'h0000_0A0A);
      else            step(1'b0, 1'b1, 32'hFFFF_B0B0);
      chk("rr_valid", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), 32'(k % 2));
    end
    idle();

    // Backpressure.
    drive(1'b1, MODE_LUI, 16'h1234, 1'b0, MODE_ZERO, 16'h0, 1'b1);
    step(1'b1, 1'b0, 32'h1234_0000);
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, MODE_ZERO, 16'hFFFF, 1'b1, MODE_ZERO, 16'hFFFF, 1'b0);
      step(1'b0, 1'b0, 32'h0);
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_id", 32'(rsp_id), 32'h0);
      chk("bp_imm", rsp_imm32, 32'h1234_0000);
    end
    drive(1'b0, MODE_ZERO, 16'h0, 1'b1, MODE_SIGN, 16'hABCD, 1'b1);
    step(1'b0, 1'b1, 32'hFFFF_ABCD);
    chk("refill_valid", 32'(rsp_valid), 32'h1);
    chk("refill_id", 32'(rsp_id), 32'h1);
    idle();

    // Reset while FULL: held result is discarded, not expected at the monitor.
    drive(1'b1, MODE_ZERO, 16'h5555, 1'b0, MODE_ZERO, 16'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_5555, 1'b0);
    chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
    drive(1'b1, MODE_ZERO, 16'h0011, 1'b1, MODE_ZERO, 16'h0022, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_err", 32'(mode_err), 32'h0);
    chk("mid_rst_imm", rsp_imm32, 32'h0);
    chk("mid_rst_ready0", 32'(req0_ready), 32'h0);
    chk("mid_rst_ready1", 32'(req1_ready), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b0, 32'h0000_0011);
    step(1'b0, 1'b1, 32'h0000_0022);
    idle();
    idle();

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
